// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout and
// the interrupt-entry sequencer states.
package pipe_pkg;

  // Scoreboard entries store indices at a fixed maximum width; narrower
  // register files are zero-extended on the way in.
  localparam int RIW_MAX     = 8;
  localparam int RIW_DEFAULT = 4;

  typedef struct packed {
    logic               valid;
    logic               wrtEn;
    logic [RIW_MAX-1:0] idx;
    logic               isLoad;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// sb_match: compares one decode source operand against every scoreboard stage,
// yielding the hit vector, the youngest (lowest-stage) hit and a load-use flag.
module sb_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [RIW_MAX-1:0]    srcIdx,
  input  logic                  srcUsed,
  output logic [DEPTH-1:0]      hit,
  output logic [DEPTH-1:0]      youngest,
  output logic                  loadUse
);

  logic [DEPTH-1:0] isLoadVec;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gStage
      assign hit[gi] = srcUsed & entries[gi].valid & entries[gi].wrtEn &
                       (entries[gi].idx == srcIdx);
      assign isLoadVec[gi] = entries[gi].isLoad;
    end
  endgenerate

  // Isolate the lowest set bit: stage 0 is the most recently issued writer.
  assign youngest = hit & (~hit + DEPTH'(1));

  // Only a load still in stage 0 cannot be forwarded in time.
  assign loadUse = |(youngest & isLoadVec & DEPTH'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline controller: RAW interlock/forward select, redirect flush and
// interrupt drain/ack sequencing. Define PIPE_FORWARD_EN to enable forwarding.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = RIW_DEFAULT,
  parameter int DEPTH               = 3,
  parameter int NUM_READ_PORTS      = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       idValid,
  input  logic [NUM_READ_PORTS*REG_INDEX_BIT_WIDTH-1:0] idRdIndex,
  input  logic [NUM_READ_PORTS-1:0]                  idRdUsed,
  input  logic                                       idWrtEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]             idWrtIndex,
  input  logic                                       idIsLoad,
  input  logic                                       redirect,
  input  logic                                       intReq,
  output logic                                       stall,
  output logic                                       issue,
  output logic                                       flush,
  output logic                                       intAck,
  output logic                                       wbWrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0]             wbWrtIndex,
  output logic                                       busy,
  output logic [NUM_READ_PORTS*DEPTH-1:0]            fwdStage
);

  localparam int RIW = REG_INDEX_BIT_WIDTH;

  sb_entry_t [DEPTH-1:0]           entryReg;
  sb_entry_t                       newEntry;
  hz_state_t                       stateReg;
  hz_state_t                       stateNext;
  logic [DEPTH-1:0]                validVec;
  logic [NUM_READ_PORTS-1:0]       hitAny;
  logic [NUM_READ_PORTS-1:0]       loadUseAll;
  logic [NUM_READ_PORTS*DEPTH-1:0] youngestAll;
  logic                            hazard;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gValid
      assign validVec[gi] = entryReg[gi].valid;
    end

    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : gPort
      logic [DEPTH-1:0] hitVec;
      sb_match #(.DEPTH(DEPTH)) uMatch (
        .entries  (entryReg),
        .srcIdx   (RIW_MAX'(idRdIndex[gi*RIW +: RIW])),
        .srcUsed  (idRdUsed[gi]),
        .hit      (hitVec),
        .youngest (youngestAll[gi*DEPTH +: DEPTH]),
        .loadUse  (loadUseAll[gi])
      );
      assign hitAny[gi] = |hitVec;
    end
  endgenerate

`ifdef PIPE_FORWARD_EN
  logic unusedHit;
  assign unusedHit = ^hitAny;
  assign hazard    = |loadUseAll;
  assign fwdStage  = youngestAll;
`else
  logic unusedFwd;
  assign unusedFwd = ^{youngestAll, loadUseAll};
  assign hazard    = |hitAny;
  assign fwdStage  = '0;
`endif

  assign busy    = |validVec;
  assign stall   = (idValid & hazard) | (stateReg != IDLE);
  assign flush   = redirect | (stateReg == ACK);
  assign issue   = idValid & ~stall & ~flush;
  assign intAck  = (stateReg == ACK);
  assign wbWrtEn    = entryReg[DEPTH-1].valid & entryReg[DEPTH-1].wrtEn;
  assign wbWrtIndex = entryReg[DEPTH-1].idx[RIW-1:0];

  always_comb begin
    newEntry        = '0;
    newEntry.valid  = issue;
    newEntry.wrtEn  = issue & idWrtEn;
    newEntry.idx    = issue ? RIW_MAX'(idWrtIndex) : '0;
    newEntry.isLoad = issue & idIsLoad;
  end

  // A redirect in the same cycle as intReq wins; the request is re-sampled later.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (intReq && !redirect) stateNext = DRAIN;
      DRAIN:   if (!busy) stateNext = ACK;
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entryReg <= '0;
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
      entryReg[0] <= newEntry;
      entryReg[DEPTH-1:1] <= entryReg[DEPTH-2:0];
    end
  end

endmodule
